// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronises N_SRC asynchronous lines, latches them
// as edge- or level-mode pending bits and hands the lowest-index enabled one to the CPU.
module ext_irq_ctrl #(
    parameter int N_SRC = 31,
    parameter int VEC_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] i_ext,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE   = 2'd0;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
    localparam logic [1:0] ADDR_PENDING  = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [N_SRC-1:0] sync2_d;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] edge_sel;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c_mask;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] cand;
    logic             cand_any;
    logic [VEC_W-1:0] cand_idx;
    logic             ack_fire;
    logic             vec_load;
    logic [31:0]      status_word;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
        end else begin
            sync1   <= i_ext;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            enable   <= '0;
            edge_sel <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_ENABLE:   enable   <= cfg_wdata[N_SRC-1:0];
                ADDR_EDGE_SEL: edge_sel <= cfg_wdata[N_SRC-1:0];
                default: ;
            endcase
        end
    end

    // A fresh edge always wins over a same-cycle W1C or acknowledge on that bit.
    assign rise     = sync2 & ~sync2_d & edge_sel;
    assign w1c_mask = (cfg_we && (cfg_addr == ADDR_PENDING)) ? cfg_wdata[N_SRC-1:0] : '0;
    assign ack_fire = (state == ST_REQ) && irq_ack;
    assign ack_mask = ack_fire ? (N_SRC'(1) << irq_vec) : '0;

    assign pending_nxt = (~edge_sel & sync2)
                       | (edge_sel & (rise | (pending & ~(w1c_mask | ack_mask))));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign cand     = pending & enable;
    assign cand_any = |cand;

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        cand_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_idx = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        vec_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cand_any) begin
                    state_nxt = ST_REQ;
                    vec_load  = 1'b1;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= ST_IDLE;
            irq_vec <= '0;
        end else begin
            state <= state_nxt;
            if (vec_load) begin
                irq_vec <= cand_idx;
            end
        end
    end

    assign irq_req = (state == ST_REQ);

    always_comb begin
        status_word                = '0;
        status_word[VEC_W-1:0]     = irq_vec;
        status_word[9:8]           = state;
        cfg_rdata                  = '0;
        case (cfg_addr)
            ADDR_ENABLE:   cfg_rdata = 32'(enable);
            ADDR_EDGE_SEL: cfg_rdata = 32'(edge_sel);
            ADDR_PENDING:  cfg_rdata = 32'(pending);
            ADDR_STATUS:   cfg_rdata = status_word;
            default:       cfg_rdata = '0;
        endcase
    end

    generate
        if (N_SRC < 32) begin : g_wdata_spare
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^cfg_wdata[31:N_SRC];
        end
    endgenerate

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: register table, directed corner sequences and
// randomized traffic compared against a behavioural model of the interrupt rules.
module tb_ext_irq_ctrl;

    localparam int N_SRC = 31;
    localparam int VEC_W = 5;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [N_SRC-1:0] i_ext;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic             irq_ack;
    logic             irq_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } cfg_vec_t;

    cfg_vec_t    tbl[8];
    logic [31:0] flip;

    always #5 Clk = ~Clk;

    ext_irq_ctrl #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_ext    (i_ext),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .irq_req  (irq_req),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .irq_done (irq_done)
    );

    // Reference: samples of i_ext taken at the last three edges, pending bits, and
    // the request state as 0 idle / 1 requesting / 2 in service.
    logic [N_SRC-1:0] hist[3];
    logic [N_SRC-1:0] m_en;
    logic [N_SRC-1:0] m_edge;
    logic [N_SRC-1:0] m_pend;
    int               m_state;
    int               m_vec;

    always @(posedge Clk) begin : ref_model
        logic [N_SRC-1:0] np;
        logic [N_SRC-1:0] cand;
        logic             rising;
        logic             clr;
        int               lowest;
        int               ns;
        int               nv;
        if (!Rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            m_en    = '0;
            m_edge  = '0;
            m_pend  = '0;
            m_state = 0;
            m_vec   = 0;
        end else begin
            cand = m_pend & m_en;
            np   = '0;
            for (int i = 0; i < N_SRC; i++) begin
                rising = hist[1][i] && !hist[2][i];
                clr    = (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i])
                      || (m_state == 1 && irq_ack && m_vec == i);
                if (m_edge[i]) np[i] = rising || (m_pend[i] && !clr);
                else           np[i] = hist[1][i];
            end
            ns = m_state;
            nv = m_vec;
            if (m_state == 0) begin
                lowest = -1;
                for (int i = 0; i < N_SRC; i++) begin
                    if (cand[i] && lowest < 0) lowest = i;
                end
                if (lowest >= 0) begin
                    ns = 1;
                    nv = lowest;
                end
            end else if (m_state == 1) begin
                if (irq_ack) ns = 2;
            end else if (m_state == 2) begin
                if (irq_done) ns = 0;
            end else begin
                ns = 0;
            end
            if (cfg_we && cfg_addr == 2'd0) m_en   = cfg_wdata[N_SRC-1:0];
            if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata[N_SRC-1:0];
            m_pend  = np;
            m_state = ns;
            m_vec   = nv;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = i_ext;
        end
    end

    function automatic logic [31:0] modelRdata(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_en);
            2'd1:    return 32'(m_edge);
            2'd2:    return 32'(m_pend);
            default: return (32'(m_state) << 8) | 32'(m_vec);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                                 input logic ack, input logic done);
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        irq_ack   = ack;
        irq_done  = done;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge Clk);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
        @(negedge Clk);
        applyStimulus(1'b0, addr, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic readCheck(input logic [1:0] addr, input logic [31:0] exp, input string name);
        cfg_addr = addr;
        #1;
        checkOutput(name, cfg_rdata, exp);
    endtask

    task automatic doReset();
        @(negedge Clk);
        Rst   = 1'b0;
        i_ext = '0;
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        cycles(2);
        Rst = 1'b1;
    endtask

    task automatic pulseAck();
        irq_ack = 1'b1;
        cycles(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulseDone();
        irq_done = 1'b1;
        cycles(1);
        irq_done = 1'b0;
    endtask

    initial begin
        Rst   = 1'b0;
        i_ext = '0;
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);

        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h7FFF_FFFF};
        tbl[1] = '{2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678};
        tbl[2] = '{2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
        tbl[3] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
        tbl[4] = '{2'd0, 32'h0000_00A5, 2'd0, 32'h0000_00A5};
        tbl[5] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'h7FFF_FFFF};
        tbl[6] = '{2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000};
        tbl[7] = '{2'd3, 32'h0000_0000, 2'd0, 32'h0000_00A5};

        // Reset state
        cycles(2);
        checkOutput("reset irq_req", 32'(irq_req), 32'h0);
        checkOutput("reset irq_vec", 32'(irq_vec), 32'h0);
        for (int a = 0; a < 4; a++) readCheck(2'(a), 32'h0, $sformatf("reset rdata[%0d]", a));
        Rst = 1'b1;

        // Register write/readback table
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            applyStimulus(1'b1, tbl[i].waddr, tbl[i].wdata, 1'b0, 1'b0);
            @(negedge Clk);
            applyStimulus(1'b0, tbl[i].raddr, 32'h0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("table[%0d]", i), cfg_rdata, tbl[i].exp);
        end
        checkOutput("table irq_req", 32'(irq_req), 32'h0);

        // Edge source 1: latency, ack, done
        doReset();
        cfgWrite(2'd0, 32'h2);
        cfgWrite(2'd1, 32'h2);
        i_ext[1] = 1'b1;
        cycles(2);
        readCheck(2'd2, 32'h0, "A pending k+1");
        cycles(1);
        readCheck(2'd2, 32'h2, "A pending k+2");
        checkOutput("A irq_req k+2", 32'(irq_req), 32'h0);
        cycles(1);
        checkOutput("A irq_req k+3", 32'(irq_req), 32'h1);
        checkOutput("A irq_vec k+3", 32'(irq_vec), 32'h1);
        readCheck(2'd3, 32'h101, "A status req");
        pulseAck();
        checkOutput("A irq_req after ack", 32'(irq_req), 32'h0);
        readCheck(2'd2, 32'h0, "A pending after ack");
        readCheck(2'd3, 32'h201, "A status service");
        pulseDone();
        readCheck(2'd3, 32'h001, "A status idle");
        cycles(2);
        checkOutput("A no re-request", 32'(irq_req), 32'h0);
        i_ext = '0;

        // Short pulses: between edges vs straddling an edge
        doReset();
        cfgWrite(2'd0, 32'h2);
        cfgWrite(2'd1, 32'h2);
        #2 i_ext[1] = 1'b1;
        #2 i_ext[1] = 1'b0;
        cycles(5);
        readCheck(2'd2, 32'h0, "B short pulse pending");
        checkOutput("B short pulse irq_req", 32'(irq_req), 32'h0);
        @(negedge Clk);
        #4 i_ext[1] = 1'b1;
        #2 i_ext[1] = 1'b0;
        cycles(3);
        readCheck(2'd2, 32'h2, "B straddle pending");
        cycles(1);
        checkOutput("B straddle irq_req", 32'(irq_req), 32'h1);
        checkOutput("B straddle irq_vec", 32'(irq_vec), 32'h1);

        // Priority: sources 3 and 7
        doReset();
        cfgWrite(2'd0, 32'h88);
        cfgWrite(2'd1, 32'h88);
        i_ext = N_SRC'(32'h88);
        cycles(4);
        checkOutput("C irq_req first", 32'(irq_req), 32'h1);
        checkOutput("C irq_vec first", 32'(irq_vec), 32'h3);
        readCheck(2'd2, 32'h88, "C pending both");
        pulseAck();
        readCheck(2'd2, 32'h80, "C pending after ack");
        readCheck(2'd3, 32'h203, "C status service");
        pulseDone();
        checkOutput("C irq_req idle", 32'(irq_req), 32'h0);
        readCheck(2'd3, 32'h003, "C status idle");
        cycles(1);
        checkOutput("C irq_req second", 32'(irq_req), 32'h1);
        checkOutput("C irq_vec second", 32'(irq_vec), 32'h7);
        i_ext = '0;

        // Level source 4 held high re-requests after done
        doReset();
        cfgWrite(2'd0, 32'h10);
        i_ext = N_SRC'(32'h10);
        cycles(4);
        checkOutput("D irq_req", 32'(irq_req), 32'h1);
        checkOutput("D irq_vec", 32'(irq_vec), 32'h4);
        pulseAck();
        readCheck(2'd3, 32'h204, "D status service");
        readCheck(2'd2, 32'h10, "D level pending kept");
        pulseDone();
        checkOutput("D irq_req idle", 32'(irq_req), 32'h0);
        readCheck(2'd3, 32'h004, "D status idle");
        cycles(1);
        checkOutput("D re-request", 32'(irq_req), 32'h1);
        checkOutput("D re-request vec", 32'(irq_vec), 32'h4);
        i_ext = '0;

        // W1C colliding with a fresh edge on bit 2
        doReset();
        cfgWrite(2'd1, 32'h4);
        i_ext[2] = 1'b1;
        cycles(3);
        readCheck(2'd2, 32'h4, "E first edge");
        i_ext = '0;
        cycles(4);
        readCheck(2'd2, 32'h4, "E pending held");
        @(negedge Clk);
        i_ext[2] = 1'b1;
        cycles(2);
        applyStimulus(1'b1, 2'd2, 32'h4, 1'b0, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
        readCheck(2'd2, 32'h4, "E set beats W1C");
        cfgWrite(2'd2, 32'h4);
        readCheck(2'd2, 32'h0, "E plain W1C");
        i_ext = '0;

        // Reset while in service
        doReset();
        cfgWrite(2'd0, 32'h2);
        cfgWrite(2'd1, 32'h2);
        i_ext = N_SRC'(32'h2);
        cycles(4);
        pulseAck();
        readCheck(2'd3, 32'h201, "F status service");
        @(negedge Clk);
        Rst = 1'b0;
        cycles(1);
        checkOutput("F irq_req in reset", 32'(irq_req), 32'h0);
        checkOutput("F irq_vec in reset", 32'(irq_vec), 32'h0);
        for (int a = 0; a < 4; a++) readCheck(2'(a), 32'h0, $sformatf("F rdata[%0d]", a));
        Rst   = 1'b1;
        i_ext = '0;

        // Randomized traffic against the reference model
        doReset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            checkOutput("rnd irq_req", 32'(irq_req), (m_state == 1) ? 32'h1 : 32'h0);
            checkOutput("rnd irq_vec", 32'(irq_vec), 32'(m_vec));
            checkOutput($sformatf("rnd rdata[%0d]", cfg_addr), cfg_rdata, modelRdata(cfg_addr));
            Rst  = ($urandom_range(0, 149) != 0);
            flip = $urandom & $urandom;
            if ($urandom_range(0, 7) != 0) flip = flip & 32'hFF;
            i_ext = i_ext ^ flip[N_SRC-1:0];
            applyStimulus(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), $urandom,
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
